// File: rtl/spi_keys_pkg.sv
// spi_keys_pkg: opcodes and SPI FSM states shared by the key scanner blocks.
package spi_keys_pkg;
    localparam logic [7:0] OP_READ_STATE   = 8'h01;
    localparam logic [7:0] OP_READ_CHANGES = 8'h02;
    localparam logic [7:0] OP_READ_ID      = 8'h03;
    typedef enum logic [1:0] {IDLE, OPCODE, INDEX, DATA} spi_state_t;
endpackage

// File: rtl/spi_keys_debounce.sv
// spi_keys_debounce: key synchroniser, tick prescaler and per-key debounce/change flags.
module spi_keys_debounce #(
    parameter int NUM_KEYS     = 89,
    parameter int DEBOUNCE_DIV = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_KEYS-1:0] i_keys,
    input  logic [NUM_KEYS-1:0] i_clr,
    output logic [NUM_KEYS-1:0] o_db,
    output logic [NUM_KEYS-1:0] o_chg
);
    localparam int CW = $clog2(DEBOUNCE_DIV);
    logic [CW-1:0]       r_cnt;
    logic [NUM_KEYS-1:0] r_s1, r_s2, r_samp, r_db, r_chg;
    logic                w_tick;
    logic [NUM_KEYS-1:0] w_eq, w_db_n;
    assign w_tick = r_cnt == CW'(DEBOUNCE_DIV - 1);
    assign w_eq   = ~(r_s2 ^ r_samp);
    assign w_db_n = w_tick ? ((r_s2 & w_eq) | (r_db & ~w_eq)) : r_db;
    assign o_db   = r_db;
    assign o_chg  = r_chg;
    // a db transition sets the flag even when the same flag is being cleared
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_s1   <= '0;
            r_s2   <= '0;
            r_samp <= '0;
            r_db   <= '0;
            r_chg  <= '0;
        end else begin
            r_cnt  <= w_tick ? '0 : r_cnt + CW'(1);
            r_s1   <= i_keys;
            r_s2   <= r_s1;
            r_samp <= w_tick ? r_s2 : r_samp;
            r_db   <= w_db_n;
            r_chg  <= (r_chg & ~i_clr) | (r_db ^ w_db_n);
        end
    end
endmodule

// File: rtl/spi_keys_burst.sv
// spi_keys_burst: debounced key matrix readable over a mode-0 SPI slave with burst reads.
module spi_keys_burst
    import spi_keys_pkg::*;
#(
    parameter int         NUM_KEYS     = 89,
    parameter int         DEBOUNCE_DIV = 1024,
    parameter logic [7:0] DEV_ID       = 8'hA5
) (
    input  logic                clk_g_i,
    input  logic                rstn_g_i,
    input  logic                spi_clk_g_i,
    input  logic                spi_cs_g_i,
    input  logic                spi_mosi_g_i,
    output logic                spi_miso_g_o,
    input  logic [NUM_KEYS-1:0] keys_i_g,
    output logic                irq_g_o
);
    spi_state_t          r_state;
    logic [2:0]          r_sclk, r_cs;
    logic [1:0]          r_mosi, r_nbyte;
    logic [2:0]          r_bit;
    logic [6:0]          r_sh_in, r_sh_out;
    logic [7:0]          r_op, r_idx;
    logic                r_skip, r_miso, r_irq;
    logic                w_rise, w_fall, w_last, w_load, w_clr_en;
    logic [7:0]          w_byte_in, w_idx, w_st, w_ch, w_resp;
    logic [NUM_KEYS-1:0] w_db, w_chg, w_clr;
    logic [511:0]        w_db_pad, w_chg_pad;

    spi_keys_debounce #(.NUM_KEYS(NUM_KEYS), .DEBOUNCE_DIV(DEBOUNCE_DIV)) u_deb (
        .i_clk(clk_g_i), .i_rst_n(rstn_g_i), .i_keys(keys_i_g), .i_clr(w_clr),
        .o_db(w_db), .o_chg(w_chg)
    );

    assign w_rise    = r_sclk[1] & ~r_sclk[2];
    assign w_fall    = ~r_sclk[1] & r_sclk[2];
    assign w_last    = r_bit == 3'd7;
    assign w_byte_in = {r_sh_in, r_mosi[1]};
    assign w_load    = w_rise && w_last && !r_cs[1] && (r_state == INDEX || r_state == DATA);
    assign w_clr_en  = w_load && r_op == OP_READ_CHANGES;
    assign w_idx     = (r_state == INDEX) ? w_byte_in : r_idx;
    assign w_db_pad  = 512'(w_db);
    assign w_chg_pad = 512'(w_chg);
    assign w_resp    = (r_op == OP_READ_STATE)   ? w_st :
                       (r_op == OP_READ_CHANGES) ? w_ch :
                       (r_op == OP_READ_ID)      ? ((r_nbyte == 2'd0) ? DEV_ID :
                                                    (r_nbyte == 2'd1) ? 8'(NUM_KEYS) : 8'h00) : 8'h00;
    assign spi_miso_g_o = r_miso;
    assign irq_g_o      = r_irq;

    // zero padding makes positions past NUM_KEYS (and past 255) read as 0
    always_comb begin
        w_st  = '0;
        w_ch  = '0;
        w_clr = '0;
        for (int j = 0; j < 8; j++) begin
            w_st[7-j] = w_db_pad[{1'b0, w_idx} + 9'(j)];
            w_ch[7-j] = w_chg_pad[{1'b0, w_idx} + 9'(j)];
        end
        for (int k = 0; k < NUM_KEYS; k++)
            w_clr[k] = w_clr_en && ((9'(k) - {1'b0, w_idx}) < 9'd8);
    end

    always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            r_sclk   <= '0;
            r_cs     <= '0;
            r_mosi   <= '0;
            r_state  <= IDLE;
            r_bit    <= '0;
            r_sh_in  <= '0;
            r_sh_out <= '0;
            r_op     <= '0;
            r_idx    <= '0;
            r_nbyte  <= '0;
            r_skip   <= 1'b0;
            r_miso   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_sclk <= {r_sclk[1:0], spi_clk_g_i};
            r_cs   <= {r_cs[1:0], spi_cs_g_i};
            r_mosi <= {r_mosi[0], spi_mosi_g_i};
            r_irq  <= |w_chg;
            if (r_cs[1]) begin
                r_state  <= IDLE;
                r_bit    <= '0;
                r_sh_in  <= '0;
                r_sh_out <= '0;
                r_nbyte  <= '0;
                r_skip   <= 1'b0;
                r_miso   <= 1'b0;
            end else if (r_state == IDLE) begin
                r_state <= r_cs[2] ? OPCODE : IDLE;
            end else if (w_rise) begin
                r_bit   <= r_bit + 3'd1;
                r_sh_in <= w_byte_in[6:0];
                if (w_last && r_state == OPCODE) begin
                    r_op    <= w_byte_in;
                    r_state <= INDEX;
                end else if (w_last) begin
                    // the byte-completing edge presents bit 7 at once; the next fall must not shift
                    r_state  <= DATA;
                    r_idx    <= w_idx + 8'd8;
                    r_sh_out <= w_resp[6:0];
                    r_miso   <= w_resp[7];
                    r_skip   <= 1'b1;
                    r_nbyte  <= (r_nbyte == 2'd2) ? 2'd2 : r_nbyte + 2'd1;
                end
            end else if (w_fall) begin
                r_skip   <= 1'b0;
                r_sh_out <= (r_state == DATA && !r_skip) ? {r_sh_out[5:0], 1'b0} : r_sh_out;
                r_miso   <= (r_state == DATA && !r_skip) ? r_sh_out[6] : r_miso;
            end
        end
    end
endmodule

// File: tb/tb_spi_keys_burst.sv
// tb_spi_keys_burst: scoreboard bench driving SPI bursts and key stimulus against a key/flag model.
module tb_spi_keys_burst;
    import spi_keys_pkg::*;
    localparam int NK = 89, DIV = 4, HALF = 8;
    logic clk = 1'b0, rstn = 1'b0, sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
    logic miso, irq;
    logic [NK-1:0] keys = '0;
    logic [255:0] mdl_db = '0, mdl_chg = '0;
    logic [7:0] exp_q[$];
    int n_vec = 0, n_err = 0;

    spi_keys_burst #(.NUM_KEYS(NK), .DEBOUNCE_DIV(DIV), .DEV_ID(8'hA5)) dut (
        .clk_g_i(clk), .rstn_g_i(rstn), .spi_clk_g_i(sclk), .spi_cs_g_i(cs),
        .spi_mosi_g_i(mosi), .spi_miso_g_o(miso), .keys_i_g(keys), .irq_g_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [7:0] mdl_byte(input logic [255:0] v, input logic [7:0] idx);
        logic [7:0] r;
        for (int j = 0; j < 8; j++)
            r[7-j] = (int'(idx) + j < NK) ? v[int'(idx) + j] : 1'b0;
        return r;
    endfunction

    task automatic push_read(input logic [7:0] op, input logic [7:0] idx, input int nb);
        logic [7:0] a;
        for (int n = 0; n < nb; n++) begin
            a = idx + 8'(8 * n);
            if (op == OP_READ_STATE) exp_q.push_back(mdl_byte(mdl_db, a));
            else if (op == OP_READ_CHANGES) begin
                exp_q.push_back(mdl_byte(mdl_chg, a));
                for (int j = 0; j < 8; j++)
                    if (int'(a) + j < NK) mdl_chg[int'(a) + j] = 1'b0;
            end
            else if (op == OP_READ_ID) exp_q.push_back(n == 0 ? 8'hA5 : n == 1 ? 8'(NK) : 8'h00);
            else exp_q.push_back(8'h00);
        end
    endtask

    task automatic set_keys(input logic [NK-1:0] v);
        keys = v;
        repeat (5 * DIV) @(negedge clk);
        for (int k = 0; k < NK; k++)
            if (mdl_db[k] !== v[k]) begin
                mdl_chg[k] = 1'b1;
                mdl_db[k] = v[k];
            end
    endtask

    task automatic spi_bit(input logic d, input int tog, output logic q);
        mosi = d;
        for (int c = 0; c < HALF; c++) begin
            @(negedge clk);
            if (c == HALF - 1 - tog) keys[10] = ~keys[10];
        end
        q = miso;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_txn(input logic [7:0] op, input logic [7:0] idx, input int nb, input bit chk,
                           input int tog, input string tag, output logic [7:0] last);
        logic [7:0] rx, ex;
        logic m, z;
        z = 1'b1;
        rx = '0;
        if (chk) push_read(op, idx, nb);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < nb + 2; b++)
            for (int i = 7; i >= 0; i--) begin
                spi_bit(b == 0 ? op[i] : b == 1 ? idx[i] : 1'b0, (b == 1 && i == 0) ? tog : -1, m);
                rx[i] = m;
                if (b < 2 && m !== 1'b0) z = 1'b0;
                if (chk && b >= 2 && i == 0) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL %s byte %0d: got %h, no expected entry", tag, b - 2, rx);
                    end else begin
                        ex = exp_q.pop_front();
                        if (rx !== ex) begin
                            n_err++;
                            $display("FAIL %s byte %0d: got %h expected %h", tag, b - 2, rx, ex);
                        end
                    end
                end
            end
        last = rx;
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        if (chk) begin
            n_vec++;
            if (z !== 1'b1 || miso !== 1'b0) begin
                n_err++;
                $display("FAIL %s framing: header-miso-zero=%b idle-miso=%b, required 1 and 0", tag, z, miso);
            end
        end
    endtask

    task automatic rd(input logic [7:0] op, input logic [7:0] idx, input int nb, input string tag);
        logic [7:0] dummy;
        spi_txn(op, idx, nb, 1'b1, -1, tag, dummy);
    endtask

    task automatic chk_irq(input logic e, input string tag);
        n_vec++;
        if (irq !== e) begin
            n_err++;
            $display("FAIL %s: irq=%b expected %b", tag, irq, e);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_vec++;
        if (miso !== 1'b0 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: miso=%b irq=%b expected 0 0", miso, irq);
        end
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        n_vec++;
        if (miso !== 1'b0 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: miso=%b irq=%b expected 0 0", miso, irq);
        end
        rd(OP_READ_STATE, 8'h00, 1, "reset_state");
    endtask

    task automatic test_debounce;
        logic got;
        logic [NK-1:0] v;
        got = 1'b0;
        keys[5] = 1'b1;
        for (int c = 0; c < 3 * DIV + 4 && !got; c++) begin
            @(negedge clk);
            got = irq;
        end
        n_vec++;
        if (got !== 1'b1) begin
            n_err++;
            $display("FAIL key5_irq: irq=%b within 3 ticks, expected 1", got);
        end
        set_keys(keys);
        rd(OP_READ_STATE, 8'h00, 1, "key5_state");
        rd(OP_READ_CHANGES, 8'h00, 1, "key5_changes");
        chk_irq(1'b0, "irq_after_clear");
        keys[6] = 1'b1;
        repeat (DIV) @(negedge clk);
        keys[6] = 1'b0;
        v = keys;
        set_keys(v);
        chk_irq(1'b0, "glitch_irq");
        rd(OP_READ_STATE, 8'h00, 1, "glitch_state");
        rd(OP_READ_CHANGES, 8'h00, 1, "glitch_changes");
    endtask

    task automatic test_state;
        logic [NK-1:0] v;
        v = '0;
        v[0] = 1'b1;
        v[9] = 1'b1;
        v[88] = 1'b1;
        set_keys(v);
        chk_irq(1'b1, "irq_keys_pressed");
        rd(OP_READ_STATE, 8'h00, 12, "burst_state");
        rd(OP_READ_CHANGES, 8'h00, 12, "burst_changes");
        chk_irq(1'b0, "irq_all_cleared");
    endtask

    task automatic test_changes;
        logic [NK-1:0] v;
        v = keys;
        v[3] = 1'b1;
        set_keys(v);
        chk_irq(1'b1, "key3_irq");
        rd(OP_READ_CHANGES, 8'h00, 1, "key3_changes");
        chk_irq(1'b0, "key3_irq_fall");
        rd(OP_READ_CHANGES, 8'h00, 1, "key3_reread");
    endtask

    task automatic test_id;
        logic [NK-1:0] v;
        v = keys;
        v[20] = 1'b1;
        set_keys(v);
        rd(OP_READ_ID, 8'h00, 3, "read_id");
        rd(8'h7E, 8'h10, 2, "bad_opcode");
        chk_irq(1'b1, "bad_opcode_irq");
        rd(OP_READ_CHANGES, 8'h10, 1, "key20_changes");
        rd(OP_READ_STATE, 8'h00, 2, "state_after_bad");
    endtask

    task automatic test_abort;
        logic m;
        logic [7:0] op;
        op = OP_READ_STATE;
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 7; i >= 0; i--) spi_bit(op[i], -1, m);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, -1, m);
        cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        rd(OP_READ_STATE, 8'h08, 1, "after_abort");
    endtask

    task automatic test_back_to_back;
        logic [7:0] r1, r2;
        for (int k = 0; k < 8; k++) begin
            spi_txn(OP_READ_CHANGES, 8'h08, 1, 1'b0, k, "race1", r1);
            spi_txn(OP_READ_CHANGES, 8'h08, 1, 1'b0, -1, "race2", r2);
            n_vec++;
            if (int'(r1[5]) + int'(r2[5]) != 1) begin
                n_err++;
                $display("FAIL key10_race k=%0d: seen %0d+%0d times, expected exactly 1", k, r1[5], r2[5]);
            end
        end
        mdl_chg[15:8] = '0;
    endtask

    task automatic test_reset_mid;
        logic m;
        logic [7:0] op;
        logic [NK-1:0] v;
        v = keys;
        v[40] = 1'b1;
        set_keys(v);
        op = OP_READ_STATE;
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 7; i >= 0; i--) spi_bit(op[i], -1, m);
        for (int i = 0; i < 8; i++) spi_bit(1'b0, -1, m);
        n_vec++;
        if (miso !== 1'b1 || irq !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: miso=%b irq=%b expected 1 1", miso, irq);
        end
        rstn = 1'b0;
        #1;
        n_vec++;
        if (miso !== 1'b0 || irq !== 1'b0 || dut.w_db !== '0 || dut.w_chg !== '0) begin
            n_err++;
            $display("FAIL mid_reset: miso=%b irq=%b db=%h chg=%h expected all 0", miso, irq, dut.w_db, dut.w_chg);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic q;
            spi_bit(1'b0, -1, q);
            m = m | q;
        end
        n_vec++;
        if (m !== 1'b0) begin
            n_err++;
            $display("FAIL no_fresh_cs: miso=%b during stale CS, expected 0", m);
        end
        cs = 1'b1;
        mdl_chg = mdl_db;
        set_keys(keys);
        rd(OP_READ_STATE, 8'h00, 12, "post_reset_state");
        rd(OP_READ_CHANGES, 8'h00, 12, "post_reset_changes");
        chk_irq(1'b0, "post_reset_irq");
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_state;
        test_changes;
        test_id;
        test_abort;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
